// File: rtl/game_turn_controller.sv
//-----------------------------------------------------------------------------
// game_turn_controller
//
// Turn sequencer for a multi-player board game. One player at a time is given
// a move enable; a move request from that player is handed to the board logic
// for a single CHECK cycle, after which the board's verdict (illegal move,
// win, full board, or plain legal move) decides whether the same player
// retries, the turn passes on, or the game ends. An optional per-turn timeout
// skips players that do not move. Each new game starts with the player after
// the one who opened the previous game.
//
// PID_W must be set to clog2(NUM_PLAYERS) by the instantiating level.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module game_turn_controller #(
    parameter int NUM_PLAYERS = 2,
    parameter int PID_W       = 1,
    parameter int TIMEOUT_CYC = 0,
    parameter int MOVE_W      = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_PLAYERS-1:0] play,
    input  logic                   ill_move,
    input  logic                   win,
    input  logic                   no_space,
    input  logic                   new_game,
    output logic [NUM_PLAYERS-1:0] play_en,
    output logic [PID_W-1:0]       cur_player,
    output logic                   game_over,
    output logic [PID_W-1:0]       winner,
    output logic                   draw,
    output logic                   timeout_p,
    output logic [MOVE_W-1:0]      move_count
);

    typedef enum logic [1:0] {
        TURN  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Wait counter only needs to reach TIMEOUT_CYC-1; keep at least one bit
    // so the design still elaborates cleanly when the timeout is disabled.
    localparam int                WAIT_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int                TO_LAST_I = (TIMEOUT_CYC > 0) ? (TIMEOUT_CYC - 1) : 0;
    localparam logic [WAIT_W-1:0] TO_LAST   = TO_LAST_I[WAIT_W-1:0];
    localparam bit                TO_EN     = (TIMEOUT_CYC > 0);

    state_t              state;
    logic [PID_W-1:0]    first_player;
    logic [WAIT_W-1:0]   wait_cnt;

    logic                move_req;
    logic                timeout_hit;

    // One-hot decode of a player index, restricted to the real players so an
    // out-of-range index can never raise a bit beyond NUM_PLAYERS-1.
    function automatic logic [NUM_PLAYERS-1:0] onehot(input logic [PID_W-1:0] pid);
        logic [NUM_PLAYERS-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            r[i] = (pid == PID_W'(i));
        end
        return r;
    endfunction

    // Next player in round-robin order, wrapping from the last player to 0.
    function automatic logic [PID_W-1:0] next_pid(input logic [PID_W-1:0] pid);
        logic [PID_W-1:0] r;
        if (pid == PID_W'(NUM_PLAYERS - 1)) begin
            r = '0;
        end else begin
            r = pid + PID_W'(1);
        end
        return r;
    endfunction

    // Move counter increment that sticks at its all-ones maximum.
    function automatic logic [MOVE_W-1:0] sat_inc(input logic [MOVE_W-1:0] v);
        logic [MOVE_W-1:0] r;
        if (v == '1) begin
            r = v;
        end else begin
            r = v + MOVE_W'(1);
        end
        return r;
    endfunction

    // Only the current player's strobe counts; everyone else's is masked off.
    assign move_req    = |(play & onehot(cur_player));
    assign timeout_hit = TO_EN && (wait_cnt == TO_LAST);

    // Turn FSM with all outputs registered alongside the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= TURN;
            cur_player   <= '0;
            first_player <= '0;
            wait_cnt     <= '0;
            play_en      <= {{(NUM_PLAYERS-1){1'b0}}, 1'b1};
            move_count   <= '0;
            winner       <= '0;
            draw         <= 1'b0;
            game_over    <= 1'b0;
            timeout_p    <= 1'b0;
        end else begin
            timeout_p <= 1'b0;
            case (state)
                TURN: begin
                    if (move_req) begin
                        // A real move always wins over a coincident timeout.
                        state    <= CHECK;
                        play_en  <= '0;
                        wait_cnt <= '0;
                    end else if (timeout_hit) begin
                        cur_player <= next_pid(cur_player);
                        play_en    <= onehot(next_pid(cur_player));
                        timeout_p  <= 1'b1;
                        wait_cnt   <= '0;
                    end else if (TO_EN) begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end

                CHECK: begin
                    wait_cnt <= '0;
                    if (ill_move) begin
                        // Same player tries again; nothing is counted.
                        state   <= TURN;
                        play_en <= onehot(cur_player);
                    end else if (win) begin
                        state      <= DONE;
                        winner     <= cur_player;
                        draw       <= 1'b0;
                        game_over  <= 1'b1;
                        move_count <= sat_inc(move_count);
                    end else if (no_space) begin
                        state      <= DONE;
                        draw       <= 1'b1;
                        game_over  <= 1'b1;
                        move_count <= sat_inc(move_count);
                    end else begin
                        state      <= TURN;
                        move_count <= sat_inc(move_count);
                        cur_player <= next_pid(cur_player);
                        play_en    <= onehot(next_pid(cur_player));
                    end
                end

                DONE: begin
                    wait_cnt <= '0;
                    if (new_game) begin
                        // Rotate the opening player so starts are shared fairly.
                        state        <= TURN;
                        first_player <= next_pid(first_player);
                        cur_player   <= next_pid(first_player);
                        play_en      <= onehot(next_pid(first_player));
                        move_count   <= '0;
                        winner       <= '0;
                        draw         <= 1'b0;
                        game_over    <= 1'b0;
                    end
                end

                default: begin
                    state    <= TURN;
                    wait_cnt <= '0;
                    play_en  <= onehot(cur_player);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_turn_controller.sv
//-----------------------------------------------------------------------------
// tb_game_turn_controller
//
// Directed bench: a 2-player controller (timeout 8, 4-bit move counter) is
// driven from a table of single-cycle vectors, followed by hand sequences for
// timeout, move/timeout collision, counter saturation and asynchronous reset.
// A second 3-player instance covers player wrap-around and reset mid-CHECK.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_game_turn_controller;

    typedef struct {
        string      name;
        logic [1:0] play;
        logic       ill;
        logic       win;
        logic       nsp;
        logic       ng;
        logic [1:0] e_en;
        logic       e_cur;
        logic       e_go;
        logic       e_winner;
        logic       e_draw;
        logic       e_to;
        logic [3:0] e_mc;
    } vec_t;

    logic       clk = 1'b0;

    // 2-player instance
    logic       reset;
    logic [1:0] play;
    logic       ill_move, win, no_space, new_game;
    logic [1:0] play_en;
    logic       cur_player;
    logic       game_over;
    logic       winner;
    logic       draw;
    logic       timeout_p;
    logic [3:0] move_count;

    // 3-player instance
    logic       reset3;
    logic [2:0] play3;
    logic [2:0] play_en3;
    logic [1:0] cur_player3;
    logic       game_over3;
    logic [1:0] winner3;
    logic       draw3;
    logic       timeout_p3;
    logic [3:0] move_count3;

    int   vec_count   = 0;
    int   miscompares = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    game_turn_controller #(
        .NUM_PLAYERS(2),
        .PID_W      (1),
        .TIMEOUT_CYC(8),
        .MOVE_W     (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .play      (play),
        .ill_move  (ill_move),
        .win       (win),
        .no_space  (no_space),
        .new_game  (new_game),
        .play_en   (play_en),
        .cur_player(cur_player),
        .game_over (game_over),
        .winner    (winner),
        .draw      (draw),
        .timeout_p (timeout_p),
        .move_count(move_count)
    );

    game_turn_controller #(
        .NUM_PLAYERS(3),
        .PID_W      (2),
        .TIMEOUT_CYC(8),
        .MOVE_W     (4)
    ) dut3 (
        .clk       (clk),
        .reset     (reset3),
        .play      (play3),
        .ill_move  (1'b0),
        .win       (1'b0),
        .no_space  (1'b0),
        .new_game  (1'b0),
        .play_en   (play_en3),
        .cur_player(cur_player3),
        .game_over (game_over3),
        .winner    (winner3),
        .draw      (draw3),
        .timeout_p (timeout_p3),
        .move_count(move_count3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] p, input logic im, input logic w,
                                 input logic ns, input logic ng);
        play     = p;
        ill_move = im;
        win      = w;
        no_space = ns;
        new_game = ng;
        step();
    endtask

    task automatic checkOutput(input string name, input logic [1:0] e_en, input logic e_cur,
                               input logic e_go, input logic e_winner, input logic e_draw,
                               input logic e_to, input logic [3:0] e_mc);
        vec_count++;
        if ({play_en, cur_player, game_over, winner, draw, timeout_p, move_count} !==
            {e_en, e_cur, e_go, e_winner, e_draw, e_to, e_mc}) begin
            miscompares++;
            $display("[TB] FAIL %s: got en=%b cur=%0d go=%b win=%0d draw=%b to=%b mc=%0d, want en=%b cur=%0d go=%b win=%0d draw=%b to=%b mc=%0d",
                     name, play_en, cur_player, game_over, winner, draw, timeout_p, move_count,
                     e_en, e_cur, e_go, e_winner, e_draw, e_to, e_mc);
        end
    endtask

    task automatic check3(input string name, input logic [2:0] e_en, input logic [1:0] e_cur,
                          input logic [3:0] e_mc);
        vec_count++;
        if ({play_en3, cur_player3, move_count3, game_over3, timeout_p3} !==
            {e_en, e_cur, e_mc, 1'b0, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL %s: got en=%b cur=%0d mc=%0d go=%b to=%b, want en=%b cur=%0d mc=%0d go=0 to=0",
                     name, play_en3, cur_player3, move_count3, game_over3, timeout_p3,
                     e_en, e_cur, e_mc);
        end
    endtask

    task automatic add_vec(input string name, input logic [1:0] p, input logic im, input logic w,
                           input logic ns, input logic ng, input logic [1:0] e_en, input logic e_cur,
                           input logic e_go, input logic e_winner, input logic e_draw,
                           input logic e_to, input logic [3:0] e_mc);
        vec_t v;
        v.name = name; v.play = p; v.ill = im; v.win = w; v.nsp = ns; v.ng = ng;
        v.e_en = e_en; v.e_cur = e_cur; v.e_go = e_go; v.e_winner = e_winner;
        v.e_draw = e_draw; v.e_to = e_to; v.e_mc = e_mc;
        vecs.push_back(v);
    endtask

    function automatic logic [1:0] en_of(input logic pid);
        return pid ? 2'b10 : 2'b01;
    endfunction

    initial begin
        logic       exp_cur;
        logic [3:0] exp_mc;

        reset  = 1'b0;
        reset3 = 1'b0;
        play   = 2'b00; ill_move = 1'b0; win = 1'b0; no_space = 1'b0; new_game = 1'b0;
        play3  = 3'b000;

        //                name                    play  im w  ns ng   en    cur go wn dr to mc
        add_vec("p0 move",                       2'b01, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 4'd0);
        add_vec("p0 legal",                      2'b00, 0, 0, 0, 0, 2'b10, 1, 0, 0, 0, 0, 4'd1);
        add_vec("p0 strobe ignored",             2'b01, 0, 0, 0, 0, 2'b10, 1, 0, 0, 0, 0, 4'd1);
        add_vec("p1 move",                       2'b10, 0, 0, 0, 0, 2'b00, 1, 0, 0, 0, 0, 4'd1);
        add_vec("ill beats win",                 2'b00, 1, 1, 0, 0, 2'b10, 1, 0, 0, 0, 0, 4'd1);
        add_vec("p1 retry",                      2'b10, 0, 0, 0, 0, 2'b00, 1, 0, 0, 0, 0, 4'd1);
        add_vec("p1 legal",                      2'b00, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0, 4'd2);
        add_vec("p0 move 2",                     2'b01, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 4'd2);
        add_vec("p0 illegal",                    2'b00, 1, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0, 4'd2);
        add_vec("p1 strobe ignored a",           2'b10, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0, 4'd2);
        add_vec("p1 strobe ignored b",           2'b10, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0, 4'd2);
        add_vec("new_game in TURN",              2'b00, 0, 0, 0, 1, 2'b01, 0, 0, 0, 0, 0, 4'd2);
        add_vec("p0 move 3",                     2'b01, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 4'd2);
        add_vec("new_game in CHECK",             2'b00, 0, 0, 0, 1, 2'b10, 1, 0, 0, 0, 0, 4'd3);
        add_vec("p1 move 2",                     2'b10, 0, 0, 0, 0, 2'b00, 1, 0, 0, 0, 0, 4'd3);
        add_vec("win beats no_space",            2'b00, 0, 1, 1, 0, 2'b00, 1, 1, 1, 0, 0, 4'd4);
        add_vec("DONE ignores board",            2'b11, 1, 1, 1, 0, 2'b00, 1, 1, 1, 0, 0, 4'd4);
        add_vec("new_game rotates to p1",        2'b00, 0, 0, 0, 1, 2'b10, 1, 0, 0, 0, 0, 4'd0);
        add_vec("p1 opens",                      2'b10, 0, 0, 0, 0, 2'b00, 1, 0, 0, 0, 0, 4'd0);
        add_vec("draw",                          2'b00, 0, 0, 1, 0, 2'b00, 1, 1, 0, 1, 0, 4'd1);
        add_vec("new_game rotates to p0",        2'b00, 0, 0, 0, 1, 2'b01, 0, 0, 0, 0, 0, 4'd0);

        step();
        checkOutput("reset state", 2'b01, 0, 0, 0, 0, 0, 4'd0);
        check3("reset state 3p", 3'b001, 2'd0, 4'd0);
        reset = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].play, vecs[i].ill, vecs[i].win, vecs[i].nsp, vecs[i].ng);
            checkOutput(vecs[i].name, vecs[i].e_en, vecs[i].e_cur, vecs[i].e_go,
                        vecs[i].e_winner, vecs[i].e_draw, vecs[i].e_to, vecs[i].e_mc);
        end

        // Timeout: seven idle edges are quiet, the eighth skips player 0.
        for (int i = 0; i < 7; i++) begin
            applyStimulus(2'b00, 0, 0, 0, 0);
            checkOutput("idle before timeout", 2'b01, 0, 0, 0, 0, 0, 4'd0);
        end
        applyStimulus(2'b00, 0, 0, 0, 0);
        checkOutput("timeout fires", 2'b10, 1, 0, 0, 0, 1, 4'd0);
        applyStimulus(2'b00, 0, 0, 0, 0);
        checkOutput("timeout one cycle", 2'b10, 1, 0, 0, 0, 0, 4'd0);

        // Collision: wait counter reaches its last value, then a move arrives.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(2'b00, 0, 0, 0, 0);
            checkOutput("idle before collision", 2'b10, 1, 0, 0, 0, 0, 4'd0);
        end
        applyStimulus(2'b10, 0, 0, 0, 0);
        checkOutput("move beats timeout", 2'b00, 1, 0, 0, 0, 0, 4'd0);
        applyStimulus(2'b00, 0, 0, 0, 0);
        checkOutput("collision move legal", 2'b01, 0, 0, 0, 0, 0, 4'd1);

        // Saturation of the 4-bit move counter.
        exp_cur = 1'b0;
        exp_mc  = 4'd1;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(en_of(exp_cur), 0, 0, 0, 0);
            checkOutput("sat move", 2'b00, exp_cur, 0, 0, 0, 0, exp_mc);
            applyStimulus(2'b00, 0, 0, 0, 0);
            exp_cur = ~exp_cur;
            if (exp_mc != 4'hF) exp_mc = exp_mc + 4'd1;
            checkOutput("sat legal", en_of(exp_cur), exp_cur, 0, 0, 0, 0, exp_mc);
        end
        applyStimulus(2'b01, 0, 0, 0, 0);
        checkOutput("p0 move at max", 2'b00, 0, 0, 0, 0, 0, 4'd15);
        applyStimulus(2'b00, 0, 1, 0, 0);
        checkOutput("win at max count", 2'b00, 0, 1, 0, 0, 0, 4'd15);
        applyStimulus(2'b00, 0, 0, 0, 1);
        checkOutput("new_game p1 first", 2'b10, 1, 0, 0, 0, 0, 4'd0);
        applyStimulus(2'b10, 0, 0, 0, 0);
        checkOutput("p1 move before win", 2'b00, 1, 0, 0, 0, 0, 4'd0);
        applyStimulus(2'b00, 0, 1, 0, 0);
        checkOutput("p1 wins", 2'b00, 1, 1, 1, 0, 0, 4'd1);

        // Asynchronous reset while in DONE.
        #2 reset = 1'b0;
        #1;
        checkOutput("async reset in DONE", 2'b01, 0, 0, 0, 0, 0, 4'd0);
        applyStimulus(2'b01, 0, 1, 0, 1);
        checkOutput("held in reset", 2'b01, 0, 0, 0, 0, 0, 4'd0);
        reset = 1'b1;
        applyStimulus(2'b01, 0, 0, 0, 0);
        checkOutput("post-reset p0 move", 2'b00, 0, 0, 0, 0, 0, 4'd0);
        applyStimulus(2'b00, 0, 1, 0, 0);
        checkOutput("post-reset p0 wins", 2'b00, 0, 1, 0, 0, 0, 4'd1);
        applyStimulus(2'b00, 0, 0, 0, 1);
        checkOutput("first_player was reset", 2'b10, 1, 0, 0, 0, 0, 4'd0);
        applyStimulus(2'b00, 0, 0, 0, 0);

        // Three players: 0 -> 1 -> 2 -> 0, then reset during CHECK.
        reset3 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            logic [1:0] nk;
            nk    = 2'((k + 1) % 3);
            play3 = 3'b001 << k;
            step();
            check3("3p move", 3'b000, 2'(k), 4'(k));
            play3 = 3'b000;
            step();
            check3("3p legal", 3'b001 << nk, nk, 4'(k + 1));
        end
        play3 = 3'b001;
        step();
        check3("3p in CHECK", 3'b000, 2'd0, 4'd3);
        #2 reset3 = 1'b0;
        #1;
        check3("3p reset mid-CHECK", 3'b001, 2'd0, 4'd0);
        play3 = 3'b000;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule

// File: doc/game_turn_controller.md
GAME_TURN_CONTROLLER -- requirements
Module: game_turn_controller

Interface
REQ-001 The block SHALL have parameter NUM_PLAYERS, default 2, giving the number of players (legal 2..8).
REQ-002 The block SHALL have parameter PID_W, default 1, giving the player-index width; PID_W SHALL equal clog2(NUM_PLAYERS).
REQ-003 The block SHALL have parameter TIMEOUT_CYC, default 0, giving the move timeout in cycles; 0 disables the timeout.
REQ-004 The block SHALL have parameter MOVE_W, default 4, giving the move_count width.
REQ-005 The block SHALL use one clock and an asynchronous active-low reset, with ports named as follows:
- clk  input  1  single clock; all state changes on its rising edge.
- reset  input  1  asynchronous active-low reset.
REQ-006 The block SHALL have these remaining ports:
- play  input  NUM_PLAYERS  per-player move-request strobes.
- ill_move  input  1  board reports an illegal move; sampled in CHECK only.
- win  input  1  board reports a winning line; sampled in CHECK only.
- no_space  input  1  board reports a full board; sampled in CHECK only.
- new_game  input  1  restart request; honoured in DONE only.
- play_en  output  NUM_PLAYERS  one-hot move enable for the current player.
- cur_player  output  PID_W  index of the player whose turn it is.
- game_over  output  1  high in DONE.
- winner  output  PID_W  index of the winning player; valid when game_over=1 and draw=0.
- draw  output  1  game ended with a full board and no win.
- timeout_p  output  1  one-cycle pulse when a turn is skipped.
- move_count  output  MOVE_W  number of legal moves completed in the current game.

Function
REQ-007 The FSM SHALL have exactly three states: TURN, CHECK and DONE.
REQ-008 All outputs SHALL be registered.
REQ-009 In TURN, play_en SHALL equal onehot(cur_player); in CHECK and DONE, play_en SHALL be 0.
REQ-010 In TURN, a sampled play[cur_player]=1 SHALL move the FSM to CHECK on the next cycle.
REQ-011 play bits of non-current players SHALL be ignored in every state.
REQ-012 In TURN with TIMEOUT_CYC>0, a wait counter SHALL increment each cycle and clear on entry to TURN.
REQ-013 When the wait counter reaches TIMEOUT_CYC-1 with no accepted move, the block SHALL:
- advance cur_player by 1 modulo NUM_PLAYERS;
- pulse timeout_p for 1 cycle;
- clear the wait counter;
- remain in TURN;
- leave move_count unchanged.
REQ-014 If play[cur_player] is sampled on the same edge that the timeout fires, the move SHALL take priority and no timeout SHALL occur.
REQ-015 CHECK SHALL last exactly 1 cycle and SHALL evaluate its inputs with priority ill_move > win > no_space.
REQ-016 CHECK with ill_move=1 SHALL return the FSM to TURN with the same cur_player and an unchanged move_count.
REQ-017 CHECK with ill_move=0 and win=1 SHALL move the FSM to DONE, set winner=cur_player and draw=0, and increment move_count.
REQ-018 CHECK with ill_move=0, win=0 and no_space=1 SHALL move the FSM to DONE, set draw=1, and increment move_count.
REQ-019 CHECK with ill_move, win and no_space all 0 SHALL:
- increment move_count;
- advance cur_player modulo NUM_PLAYERS, wrapping from NUM_PLAYERS-1 to 0;
- return the FSM to TURN.
REQ-020 move_count SHALL saturate at 2^MOVE_W-1.
REQ-021 In DONE, game_over SHALL be 1 and winner, draw and move_count SHALL hold their values.
REQ-022 In DONE, all play, ill_move, win and no_space inputs SHALL be ignored.
REQ-023 new_game=1 sampled in DONE SHALL:
- increment an internal first_player register modulo NUM_PLAYERS;
- set cur_player=new first_player;
- clear move_count, winner, draw and game_over;
- enter TURN.
REQ-024 new_game SHALL be ignored in TURN and CHECK.

Reset
REQ-025 While reset=0, the FSM SHALL be in TURN with cur_player=0 and first_player=0.
REQ-026 While reset=0, the outputs SHALL be: play_en=1, move_count=0, winner=0, draw=0, game_over=0, timeout_p=0, wait counter=0.
REQ-027 Assertion of reset SHALL take effect immediately and asynchronously from any state, including mid-CHECK and DONE.
REQ-028 Deassertion of reset SHALL be honoured at the next clk edge.

Verification (NUM_PLAYERS=2 unless stated, TIMEOUT_CYC=8, MOVE_W=4)
REQ-029 Scenario: release reset, play=01 for 1 cycle, board inputs 0 -> CHECK for 1 cycle, then TURN with cur_player=1, play_en=10, move_count=1.
REQ-030 Scenario: player 0 moves and ill_move=1 in CHECK -> TURN with cur_player=0 and move_count=0; play=10 during that TURN is ignored.
REQ-031 Scenario: no play for 8 cycles in TURN -> timeout_p=1 for exactly 1 cycle, cur_player 0->1, move_count unchanged.
REQ-032 Scenario: play and timeout coincide on the same edge -> move accepted and timeout_p stays 0.
REQ-033 Scenario: player 1 moves with win=1 and no_space=1 in CHECK -> game_over=1, winner=1, draw=0; a following new_game -> cur_player=1, move_count=0.
REQ-034 Scenario: NUM_PLAYERS=3, three legal moves -> cur_player sequence 0,1,2,0; then reset=0 asserted during CHECK -> immediate cur_player=0, play_en=001.
